// File: rtl/rs232_pkg.sv
// Shared definitions for the RS-232 transmit path: serializer states,
// frame length and the clock-to-bit-period divider calculation.
package rs232_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // Start bit + 8 data bits + stop bit.
  localparam int FRAME_BITS = 10;

  function automatic int calc_div(input int mhz_v, input int baud_v);
    return (mhz_v * 1_000_000) / baud_v;
  endfunction

endpackage

// File: rtl/rs232_sync_fifo.sv
// Byte FIFO feeding the UART serializer. Full/empty come from the registered
// count only, so a write offered while full is dropped even if a pop happens.
module rs232_sync_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  input  logic                   rd_en,
  output logic [7:0]             rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW:0]   count_q;
  logic [PW:0]   count_d;
  logic          push;
  logic          pop;

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes queue in a FIFO and are serialized
// LSB first, back to back with no idle gap while the FIFO has data.
module uart_tx_fifo
  import rs232_pkg::*;
#(
  parameter int baud  = 9600,
  parameter int mhz   = 50,
  parameter int DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   tx_vld,
  input  logic [7:0]             transmit_data,
  output logic                   tx_rdy,
  output logic                   RS232_DCE_TXD,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int                 DIV       = calc_div(mhz, baud);
  localparam int                 CNT_W     = $clog2(DIV + 1);
  localparam logic [CNT_W-1:0]   BAUD_LAST = CNT_W'(DIV - 1);
  localparam logic [2:0]         LAST_BIT  = 3'(FRAME_BITS - 3);

  tx_state_e        state_q;
  logic [CNT_W-1:0] baud_q;
  logic [2:0]       idx_q;
  logic [7:0]       shift_q;
  logic             txd_q;
  logic             busy_q;
  logic             fifo_empty;
  logic             fifo_full;
  logic             bit_end;
  logic             pop_req;
  logic [7:0]       head;

  assign bit_end = (baud_q == BAUD_LAST);
  assign pop_req = (state_q == IDLE) || ((state_q == STOP) && bit_end);

  rs232_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (tx_vld),
    .wr_data (transmit_data),
    .rd_en   (pop_req),
    .rd_data (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign tx_rdy        = !fifo_full;
  assign RS232_DCE_TXD = txd_q;
  assign busy          = busy_q || !fifo_empty;

  // The line register follows the state one cycle late, which gives the
  // two-edge write-to-start-bit latency and keeps busy aligned to the stop bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      busy_q <= (state_q != IDLE) || !fifo_empty;

      case (state_q)
        START:   txd_q <= 1'b0;
        DATA:    txd_q <= shift_q[idx_q];
        default: txd_q <= 1'b1;
      endcase

      if ((state_q == IDLE) || bit_end) begin
        baud_q <= '0;
      end else begin
        baud_q <= baud_q + 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            shift_q <= head;
            state_q <= START;
          end
        end
        START: begin
          if (bit_end) begin
            idx_q   <= '0;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (idx_q == LAST_BIT) begin
              state_q <= STOP;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            if (!fifo_empty) begin
              shift_q <= head;
              state_q <= START;
            end else begin
              state_q <= IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at DIV=4: each scenario records the line
// cycle by cycle and compares it against hand-derived frame timing.
module tb_uart_tx_fifo;

  logic       clock = 1'b0;
  logic       reset;
  logic       txVld;
  logic [7:0] txData;
  logic       txRdy;
  logic       txd;
  logic       busy;
  logic [3:0] fifoCount;

  int checks   = 0;
  int failures = 0;

  logic       stimVld  [0:511];
  logic [7:0] stimData [0:511];
  logic       capLine  [0:511];
  logic       capBusy  [0:511];
  logic       capRdy   [0:511];
  logic [3:0] capCount [0:511];

  logic [7:0] expBytes [0:15];
  int         expN;
  int         expStart;

  uart_tx_fifo #(.baud(250000), .mhz(1), .DEPTH(8)) dut (
    .clock         (clock),
    .reset         (reset),
    .tx_vld        (txVld),
    .transmit_data (txData),
    .tx_rdy        (txRdy),
    .RS232_DCE_TXD (txd),
    .busy          (busy),
    .fifo_count    (fifoCount)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic clearStim;
    for (int k = 0; k < 512; k++) begin
      stimVld[k]  = 1'b0;
      stimData[k] = 8'h00;
    end
  endtask

  // Entry k is presented to edge k; captured values describe the cycle after edge k.
  task automatic runCapture(input int n);
    for (int k = 0; k < n; k++) begin
      txVld  = stimVld[k];
      txData = stimData[k];
      tick();
      capLine[k]  = txd;
      capBusy[k]  = busy;
      capRdy[k]   = txRdy;
      capCount[k] = fifoCount;
    end
    txVld = 1'b0;
  endtask

  // 40-cycle frames from expStart: 4 low, 8x4 data LSB first, 4 high.
  function automatic logic expectedLine(input int k);
    int f;
    int off;
    logic [7:0] b;
    if (k < expStart) return 1'b1;
    f = (k - expStart) / 40;
    if (f >= expN) return 1'b1;
    off = (k - expStart) % 40;
    if (off < 4) return 1'b0;
    b = expBytes[f];
    if (off < 36) return b[(off - 4) / 4];
    return 1'b1;
  endfunction

  task automatic test_reset;
    reset  = 1'b1;
    txVld  = 1'b0;
    txData = 8'h00;
    #1;
    checks++; if (txd !== 1'b1) begin failures++; $display("[TB] FAIL reset.txd got=%b exp=1", txd); end
    checks++; if (txRdy !== 1'b1) begin failures++; $display("[TB] FAIL reset.rdy got=%b exp=1", txRdy); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset.busy got=%b exp=0", busy); end
    checks++; if (fifoCount !== 4'd0) begin failures++; $display("[TB] FAIL reset.count got=%0d exp=0", fifoCount); end
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_single_byte;
    clearStim();
    stimVld[0] = 1'b1; stimData[0] = 8'hA5;
    runCapture(44);
    expBytes[0] = 8'hA5; expN = 1; expStart = 2;
    for (int k = 0; k < 44; k++) begin
      checks++;
      if (capLine[k] !== expectedLine(k)) begin
        failures++;
        $display("[TB] FAIL single.line cycle=%0d got=%b exp=%b", k, capLine[k], expectedLine(k));
      end
      checks++;
      if (capBusy[k] !== (k <= 41)) begin
        failures++;
        $display("[TB] FAIL single.busy cycle=%0d got=%b exp=%b", k, capBusy[k], (k <= 41));
      end
    end
    checks++; if (capCount[0] !== 4'd1) begin failures++; $display("[TB] FAIL single.count0 got=%0d exp=1", capCount[0]); end
    checks++; if (capCount[1] !== 4'd0) begin failures++; $display("[TB] FAIL single.count1 got=%0d exp=0", capCount[1]); end
  endtask

  task automatic test_back_to_back;
    clearStim();
    stimVld[0] = 1'b1; stimData[0] = 8'h00;
    stimVld[1] = 1'b1; stimData[1] = 8'hFF;
    stimVld[2] = 1'b1; stimData[2] = 8'h55;
    runCapture(126);
    expBytes[0] = 8'h00; expBytes[1] = 8'hFF; expBytes[2] = 8'h55;
    expN = 3; expStart = 2;
    for (int k = 0; k < 126; k++) begin
      checks++;
      if (capLine[k] !== expectedLine(k)) begin
        failures++;
        $display("[TB] FAIL b2b.line cycle=%0d got=%b exp=%b", k, capLine[k], expectedLine(k));
      end
    end
    checks++; if (capCount[2] !== 4'd2) begin failures++; $display("[TB] FAIL b2b.count2 got=%0d exp=2", capCount[2]); end
    checks++; if (capBusy[121] !== 1'b1) begin failures++; $display("[TB] FAIL b2b.busy121 got=%b exp=1", capBusy[121]); end
    checks++; if (capBusy[122] !== 1'b0) begin failures++; $display("[TB] FAIL b2b.busy122 got=%b exp=0", capBusy[122]); end
  endtask

  task automatic test_full_fifo;
    clearStim();
    for (int k = 0; k < 10; k++) begin
      stimVld[k]  = 1'b1;
      stimData[k] = 8'(k + 1);
    end
    runCapture(370);
    for (int k = 0; k < 9; k++) expBytes[k] = 8'(k + 1);
    expN = 9; expStart = 2;
    for (int k = 0; k < 370; k++) begin
      checks++;
      if (capLine[k] !== expectedLine(k)) begin
        failures++;
        $display("[TB] FAIL full.line cycle=%0d got=%b exp=%b", k, capLine[k], expectedLine(k));
      end
    end
    checks++; if (capRdy[7] !== 1'b1) begin failures++; $display("[TB] FAIL full.rdy7 got=%b exp=1", capRdy[7]); end
    checks++; if (capCount[8] !== 4'd8) begin failures++; $display("[TB] FAIL full.count8 got=%0d exp=8", capCount[8]); end
    checks++; if (capRdy[8] !== 1'b0) begin failures++; $display("[TB] FAIL full.rdy8 got=%b exp=0", capRdy[8]); end
    checks++; if (capCount[9] !== 4'd8) begin failures++; $display("[TB] FAIL full.count9 got=%0d exp=8", capCount[9]); end
    checks++; if (capBusy[361] !== 1'b1) begin failures++; $display("[TB] FAIL full.busy361 got=%b exp=1", capBusy[361]); end
    checks++; if (capBusy[362] !== 1'b0) begin failures++; $display("[TB] FAIL full.busy362 got=%b exp=0", capBusy[362]); end
  endtask

  task automatic test_simultaneous;
    clearStim();
    stimVld[0]  = 1'b1; stimData[0]  = 8'h11;
    stimVld[1]  = 1'b1; stimData[1]  = 8'h22;
    stimVld[41] = 1'b1; stimData[41] = 8'h3C;
    runCapture(130);
    expBytes[0] = 8'h11; expBytes[1] = 8'h22; expBytes[2] = 8'h3C;
    expN = 3; expStart = 2;
    for (int k = 0; k < 130; k++) begin
      checks++;
      if (capLine[k] !== expectedLine(k)) begin
        failures++;
        $display("[TB] FAIL simul.line cycle=%0d got=%b exp=%b", k, capLine[k], expectedLine(k));
      end
    end
    checks++; if (capCount[1] !== 4'd1) begin failures++; $display("[TB] FAIL simul.count1 got=%0d exp=1", capCount[1]); end
    checks++; if (capCount[40] !== 4'd1) begin failures++; $display("[TB] FAIL simul.count40 got=%0d exp=1", capCount[40]); end
    checks++; if (capCount[41] !== 4'd1) begin failures++; $display("[TB] FAIL simul.count41 got=%0d exp=1", capCount[41]); end
    checks++; if (capCount[81] !== 4'd0) begin failures++; $display("[TB] FAIL simul.count81 got=%0d exp=0", capCount[81]); end
  endtask

  task automatic test_reset_mid_frame;
    clearStim();
    stimVld[0] = 1'b1; stimData[0] = 8'h81;
    stimVld[1] = 1'b1; stimData[1] = 8'h99;
    stimVld[2] = 1'b1; stimData[2] = 8'h66;
    runCapture(20);
    expBytes[0] = 8'h81; expN = 1; expStart = 2;
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (capLine[k] !== expectedLine(k)) begin
        failures++;
        $display("[TB] FAIL midrst.pre cycle=%0d got=%b exp=%b", k, capLine[k], expectedLine(k));
      end
    end
    checks++; if (capCount[19] !== 4'd2) begin failures++; $display("[TB] FAIL midrst.queued got=%0d exp=2", capCount[19]); end
    reset = 1'b1;
    #1;
    checks++; if (txd !== 1'b1) begin failures++; $display("[TB] FAIL midrst.txd got=%b exp=1", txd); end
    checks++; if (fifoCount !== 4'd0) begin failures++; $display("[TB] FAIL midrst.count got=%0d exp=0", fifoCount); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst.busy got=%b exp=0", busy); end
    checks++; if (txRdy !== 1'b1) begin failures++; $display("[TB] FAIL midrst.rdy got=%b exp=1", txRdy); end
    tick();
    tick();
    checks++; if (txd !== 1'b1) begin failures++; $display("[TB] FAIL midrst.hold got=%b exp=1", txd); end
    reset = 1'b0;
    tick();
    clearStim();
    stimVld[0] = 1'b1; stimData[0] = 8'h42;
    runCapture(60);
    expBytes[0] = 8'h42; expN = 1; expStart = 2;
    for (int k = 0; k < 60; k++) begin
      checks++;
      if (capLine[k] !== expectedLine(k)) begin
        failures++;
        $display("[TB] FAIL midrst.post cycle=%0d got=%b exp=%b", k, capLine[k], expectedLine(k));
      end
    end
    checks++; if (capCount[0] !== 4'd1) begin failures++; $display("[TB] FAIL midrst.count0 got=%0d exp=1", capCount[0]); end
    checks++; if (capBusy[42] !== 1'b0) begin failures++; $display("[TB] FAIL midrst.busy42 got=%b exp=0", capBusy[42]); end
  endtask

  initial begin
    $display("[TB] uart_tx_fifo directed bench, DIV=4");
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_full_fifo();
    test_simultaneous();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
